// File: rtl/node_integrator_pkg.sv
// Shared definitions for the switch-level node models.
//   W, HI, LO : node voltage width and rails (mirror the common header macros)
//   volt_t    : signed node voltage
//   wide_t    : wide signed scratch type for intermediate sums
//   sat_w()   : clamp a wide signed value to [LO, HI]
//   node_state_t : integrator settle state
package monta_pkg;

  localparam int W = 16;

  typedef logic signed [W-1:0] volt_t;
  typedef logic signed [31:0]  wide_t;

  localparam volt_t HI = volt_t'(16384);
  localparam volt_t LO = volt_t'(-16384);

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_SETTLED = 1'b1
  } node_state_t;

  function automatic volt_t sat_w(input wide_t x);
    if (x > wide_t'(HI)) begin
      return HI;
    end else if (x < wide_t'(LO)) begin
      return LO;
    end
    return volt_t'(x);
  endfunction

endpackage

// File: rtl/node_integrator_current_sum.sv
// Combinational sum of N_IN packed signed branch currents.
//   i_in : N_IN * W packed currents, slice k is i_in[k*W +: W]
//   sum  : exact signed sum, SW bits (caller sizes SW so it cannot wrap)
module current_sum
  import monta_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SW   = W + 3
) (
  input  logic [N_IN*W-1:0]    i_in,
  output logic signed [SW-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = sum + SW'($signed(i_in[k*W +: W]));
    end
  end

endmodule

// File: rtl/node_integrator.sv
// Per-node state element: sums branch currents, scales by the node
// capacitance shift and integrates into the registered node voltage.
//   clk      : simulation clock
//   reset    : asynchronous, active-high
//   en       : integrate enable; all state holds when low
//   load     : synchronous preset of the voltage (wins over en)
//   load_v   : signed preset value, clamped to [LO, HI]
//   i_in     : N_IN packed signed currents
//   v        : registered signed node voltage
//   logic_hi : registered logic-level view of v (sign bit inverted)
//   settled  : node has been quiescent for SETTLE_CYCLES enabled cycles
//   sat_flag : sticky clamp indicator since the last reset or load
module node_integrator
  import monta_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int CSHIFT        = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int INIT_HI       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [W-1:0]      load_v,
  input  logic [N_IN*W-1:0] i_in,
  output logic [W-1:0]      v,
  output logic              logic_hi,
  output logic              settled,
  output logic              sat_flag
);

  localparam int SW = W + $clog2(N_IN) + 1;
  localparam int VW = SW + 1;
  localparam volt_t V_INIT = (INIT_HI != 0) ? HI : LO;
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

  volt_t v_q;
  logic  hi_q;
  logic  sat_q;
  logic [7:0] cnt_q, cnt_n;
  node_state_t state_q, state_n;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [VW-1:0] vn;
  volt_t v_next;
  volt_t v_load;
  logic  clamp;
  logic  delta_neg;
  logic  delta_zero;
  logic  quiet;

  // Only combinational path in the block: i_in through the adder.
  current_sum #(
    .N_IN (N_IN),
    .SW   (SW)
  ) u_sum (
    .i_in (i_in),
    .sum  (sum)
  );

  assign delta      = sum >>> CSHIFT;
  assign vn         = VW'(v_q) + VW'(delta);
  assign v_next     = sat_w(wide_t'(vn));
  assign v_load     = sat_w(wide_t'($signed(load_v)));
  assign clamp      = (wide_t'(vn) > wide_t'(HI)) || (wide_t'(vn) < wide_t'(LO));
  assign delta_neg  = delta[SW-1];
  assign delta_zero = (delta == '0);

  // A node pinned at the rail its current drives toward is as quiet as
  // one with zero net current: further integration cannot move it.
  assign quiet = delta_zero
              || (!delta_neg && v_next == HI)
              || ( delta_neg && v_next == LO);

  always_comb begin
    cnt_n   = cnt_q;
    state_n = state_q;
    if (load) begin
      cnt_n   = '0;
      state_n = ST_ACTIVE;
    end else if (en) begin
      if (!quiet) begin
        cnt_n = '0;
      end else if (cnt_q != SETTLE_N) begin
        cnt_n = cnt_q + 8'd1;
      end
      state_n = (cnt_n == SETTLE_N) ? ST_SETTLED : ST_ACTIVE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= V_INIT;
      hi_q  <= ~V_INIT[W-1];
      sat_q <= 1'b0;
    end else if (load) begin
      v_q   <= v_load;
      hi_q  <= ~v_load[W-1];
      sat_q <= 1'b0;
    end else if (en) begin
      v_q  <= v_next;
      hi_q <= ~v_next[W-1];
      if (clamp) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign v        = v_q;
  assign logic_hi = hi_q;
  assign settled  = (state_q == ST_SETTLED);
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_node_integrator.sv
module tb_node_integrator;

  localparam int W    = 16;
  localparam int N_IN = 4;
  localparam int VHI  = 16384;
  localparam int VLO  = -16384;
  localparam int SETN = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              load;
  logic [W-1:0]      load_v;
  logic [N_IN*W-1:0] i_in;
  logic [W-1:0]      v;
  logic              logic_hi;
  logic              settled;
  logic              sat_flag;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int  m_v;
  int  m_cnt;
  bit  m_set;
  bit  m_sat;

  node_integrator #(
    .N_IN          (N_IN),
    .CSHIFT        (2),
    .SETTLE_CYCLES (SETN),
    .INIT_HI       (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_v   (load_v),
    .i_in     (i_in),
    .v        (v),
    .logic_hi (logic_hi),
    .settled  (settled),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld;
    int lv;
    bit en;
    int c0, c1, c2, c3;
    int ev;
    bit es;
    bit esat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit ld, int lv, bit e, int c0, int c1, int c2, int c3,
                              int ev, bit es, bit esat);
    vec_t r;
    r.ld = ld; r.lv = lv; r.en = e;
    r.c0 = c0; r.c1 = c1; r.c2 = c2; r.c3 = c3;
    r.ev = ev; r.es = es; r.esat = esat;
    return r;
  endfunction

  function automatic int clampv(int x);
    if (x > VHI) return VHI;
    if (x < VLO) return VLO;
    return x;
  endfunction

  // floor(s / 4): the capacitance scaling rounds toward minus infinity
  function automatic int floor4(int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic void model_step(bit ld, int lv, bit e, int c0, int c1, int c2, int c3);
    int d, vn, nv;
    bit rest;
    if (ld) begin
      m_v = clampv(lv); m_cnt = 0; m_set = 0; m_sat = 0;
    end else if (e) begin
      d  = floor4(c0 + c1 + c2 + c3);
      vn = m_v + d;
      nv = clampv(vn);
      if (nv != vn) m_sat = 1;
      rest = (d == 0) || (d > 0 && nv == VHI) || (d < 0 && nv == VLO);
      m_cnt = rest ? ((m_cnt + 1 > SETN) ? SETN : m_cnt + 1) : 0;
      m_set = (m_cnt == SETN);
      m_v = nv;
    end
  endfunction

  task automatic drive(bit ld, int lv, bit e, int c0, int c1, int c2, int c3);
    load   = ld;
    load_v = 16'(lv);
    en     = e;
    i_in   = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  task automatic check(input string nm, input int ev, input bit es, input bit esat);
    bit ehi;
    ehi = (ev >= 0);
    vectors++;
    if (v !== 16'(ev) || logic_hi !== ehi || settled !== es || sat_flag !== esat) begin
      miscompares++;
      $display("FAIL %s: got v=%0d logic_hi=%0b settled=%0b sat_flag=%0b, want v=%0d logic_hi=%0b settled=%0b sat_flag=%0b",
               nm, $signed(v), logic_hi, settled, sat_flag, ev, ehi, es, esat);
    end
  endtask

  function automatic int rnd_cur(int mode);
    case (mode)
      0: return 0;
      1: return int'($urandom_range(0, 6)) - 3;
      2: return int'($urandom_range(0, 65535)) - 32768;
      default: return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset_state", VLO, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // preset to 0, integrate +100 three times
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 100, 0, 0, 0, 25, 0, 0));
    tbl.push_back(mk(0, 0, 1, 100, 0, 0, 0, 50, 0, 0));
    tbl.push_back(mk(0, 0, 1, 100, 0, 0, 0, 75, 0, 0));
    // arithmetic shift rounds -3/4 down to -1; then zero-delta settling
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, -3, 0, 0, 0, -1, 0, 0));
    tbl.push_back(mk(0, 0, 1, -3, 0, 0, 0, -2, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, -2, (k >= 8), 0));
    // positive clamp, then load beats en and clears flags
    tbl.push_back(mk(1, 16000, 0, 0, 0, 0, 0, 16000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8000, 8000, 8000, 8000, VHI, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8000, 8000, 8000, 8000, VHI, 0, 1));
    tbl.push_back(mk(1, 16000, 1, 8000, 8000, 8000, 8000, 16000, 0, 0));
    // en low holds everything despite nonzero currents
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 0, 8000, 8000, 8000, 8000, 16000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4, 0, 0, 0, 16001, 0, 0));
    // load saturates; max-negative currents land exactly on LO, then clamp
    tbl.push_back(mk(1, 32767, 0, 0, 0, 0, 0, VHI, 0, 0));
    tbl.push_back(mk(0, 0, 1, -32768, -32768, -32768, -32768, VLO, 0, 0));
    for (int k = 2; k <= 9; k++)
      tbl.push_back(mk(0, 0, 1, -32768, -32768, -32768, -32768, VLO, (k >= 8), 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 0, 500, 500, 500, 500, VLO, 1, 1));
    tbl.push_back(mk(1, -32768, 0, 0, 0, 0, 0, VLO, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].es, tbl[i].esat);
    end

    // asynchronous reset in the middle of integration
    drive(1, 1000, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_reset_load", 1000, 0, 0);
    drive(0, 0, 1, 100, 100, 100, 100);
    @(posedge clk);
    #1;
    check("pre_reset_step", 1100, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", VLO, 0, 0);
    @(posedge clk);
    #1;
    check("reset_held", VLO, 0, 0);
    reset = 1'b0;
    m_v = VLO; m_cnt = 0; m_set = 0; m_sat = 0;

    // randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      int mode, c0, c1, c2, c3, lv;
      bit ld, e;
      mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 4) mode = 0;
      c0 = rnd_cur(mode); c1 = rnd_cur(mode); c2 = rnd_cur(mode); c3 = rnd_cur(mode);
      ld = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 9) != 0);
      lv = int'($urandom_range(0, 65535)) - 32768;
      drive(ld, lv, e, c0, c1, c2, c3);
      @(posedge clk);
      #1;
      model_step(ld, lv, e, c0, c1, c2, c3);
      check($sformatf("rand[%0d]", n), m_v, m_set, m_sat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
